// File: rtl/u62_serial_link_if.sv
// Command/status side of the U62 front-panel link: decoded transport pulses
// toward the top level and the status byte returned to U62.
interface u62_serial_link_if;
  logic [7:0] status_in;
  logic [7:0] cmd_byte;
  logic       cmd_valid;
  logic       cmd_play;
  logic       cmd_stop;
  logic       cmd_rewind;
  logic       cmd_ff;
  logic       cmd_idle;
  logic       cmd_unknown;
  logic       busy;

  modport master (
    input  status_in,
    output cmd_byte, cmd_valid, cmd_play, cmd_stop, cmd_rewind,
           cmd_ff, cmd_idle, cmd_unknown, busy
  );

  modport slave (
    output status_in,
    input  cmd_byte, cmd_valid, cmd_play, cmd_stop, cmd_rewind,
           cmd_ff, cmd_idle, cmd_unknown, busy
  );
endinterface

// File: rtl/u62_serial_link.sv
// Byte-serial U62 transceiver: 8-bit command in, 8-bit status out, MSB first.
// Optional stall recovery is enabled with `define U62_TIMEOUT_EN.
module u62_serial_link #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 200000,
  parameter int TIMEOUT_W      = 18
) (
  input  logic PI_CLK,
  input  logic RESET_n,
  input  logic sck_in,
  input  logic sdata_in,
  output logic sdata_out,
  output logic sdata_oe,
  u62_serial_link_if.master cmd_if
);

  localparam logic [1:0] RX_IDLE = 2'd0;
  localparam logic [1:0] RX_CMD  = 2'd1;
  localparam logic [1:0] TX_WAIT = 2'd2;
  localparam logic [1:0] TX_DATA = 2'd3;

  // pulse vector bit order: {unknown, idle, ff, rewind, stop, play}
  localparam int P_PLAY = 0;
  localparam int P_STOP = 1;
  localparam int P_REW  = 2;
  localparam int P_FF   = 3;
  localparam int P_IDLE = 4;
  localparam int P_UNK  = 5;

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be at least 2");
  end
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_W < 2 ||
      longint'(TIMEOUT_CYCLES) > (longint'(1) << TIMEOUT_W)) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must fit in TIMEOUT_W bits");
  end

  // ---------------------------------------------------------------- sync
  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
  logic                   sck_dly_q, sck_dly_d;
  logic                   sck_s, sda_s, rise, fall;

  always_comb begin
    sck_sync_d = {sck_sync_q[SYNC_STAGES-2:0], sck_in};
    sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sdata_in};
    sck_s      = sck_sync_q[SYNC_STAGES-1];
    sda_s      = sda_sync_q[SYNC_STAGES-1];
    sck_dly_d  = sck_s;
    rise       = sck_s & ~sck_dly_q;
    fall       = ~sck_s & sck_dly_q;
  end

  // Idle line is high, so reset the chain high to avoid a phantom edge.
  always_ff @(posedge PI_CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      sck_sync_q <= '1;
      sda_sync_q <= '1;
      sck_dly_q  <= 1'b1;
    end else begin
      sck_sync_q <= sck_sync_d;
      sda_sync_q <= sda_sync_d;
      sck_dly_q  <= sck_dly_d;
    end
  end

  // ---------------------------------------------------------------- FSM
  logic [1:0] state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] rx_sh_q, rx_sh_d;
  logic [7:0] tx_sh_q, tx_sh_d;
  logic [7:0] cmd_byte_q, cmd_byte_d;
  logic       cmd_valid_q, cmd_valid_d;
  logic [5:0] pulse_q, pulse_d;
  logic       oe_q, oe_d;
  logic       out_q, out_d;
  logic [7:0] new_byte;

`ifdef U62_TIMEOUT_EN
  localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
  logic [TIMEOUT_W-1:0] to_q, to_d;
  logic                 to_hit;
`endif

  function automatic logic [5:0] decode(input logic [7:0] b);
    logic [5:0] p;
    p = '0;
    case (b)
      8'b1000_0000: p[P_PLAY] = 1'b1;
      8'b0110_0000: p[P_STOP] = 1'b1;
      8'b0010_0000: p[P_REW]  = 1'b1;
      8'b0100_0000: p[P_FF]   = 1'b1;
      8'b0000_1000: p[P_IDLE] = 1'b1;
      default:      p[P_UNK]  = 1'b1;
    endcase
    return p;
  endfunction

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_sh_d     = rx_sh_q;
    tx_sh_d     = tx_sh_q;
    cmd_byte_d  = cmd_byte_q;
    cmd_valid_d = 1'b0;
    pulse_d     = '0;
    oe_d        = oe_q;
    out_d       = out_q;
    new_byte    = {rx_sh_q, sda_s};

    case (state_q)
      RX_IDLE: begin
        if (rise) begin
          rx_sh_d   = {6'b0, sda_s};
          bit_cnt_d = 3'd1;
          state_d   = RX_CMD;
        end
      end
      RX_CMD: begin
        if (rise) begin
          rx_sh_d   = new_byte[6:0];
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            cmd_byte_d  = new_byte;
            cmd_valid_d = 1'b1;
            pulse_d     = decode(new_byte);
            tx_sh_d     = cmd_if.status_in;
            bit_cnt_d   = 3'd0;
            state_d     = TX_WAIT;
          end
        end
      end
      TX_WAIT: begin
        // U62 releases SDATA on its first falling edge after the command.
        if (!rise && fall) begin
          oe_d      = 1'b1;
          out_d     = tx_sh_q[7];
          bit_cnt_d = 3'd0;
          state_d   = TX_DATA;
        end
      end
      default: begin
        if (rise) begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            oe_d      = 1'b0;
            out_d     = 1'b0;
            bit_cnt_d = 3'd0;
            state_d   = RX_IDLE;
          end
        end else if (fall) begin
          tx_sh_d = {tx_sh_q[6:0], 1'b0};
          out_d   = tx_sh_q[6];
        end
      end
    endcase

`ifdef U62_TIMEOUT_EN
    to_hit = (to_q >= TO_LAST);
    if (rise || fall || state_q == RX_IDLE) to_d = '0;
    else if (to_q != '1)                    to_d = to_q + 1'b1;
    else                                    to_d = to_q;

    if (to_hit && state_q != RX_IDLE) begin
      state_d     = RX_IDLE;
      bit_cnt_d   = 3'd0;
      rx_sh_d     = '0;
      oe_d        = 1'b0;
      out_d       = 1'b0;
      cmd_byte_d  = cmd_byte_q;
      cmd_valid_d = 1'b0;
      pulse_d     = '0;
      to_d        = '0;
    end
`endif
  end

  always_ff @(posedge PI_CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q     <= RX_IDLE;
      bit_cnt_q   <= '0;
      rx_sh_q     <= '0;
      tx_sh_q     <= '0;
      cmd_byte_q  <= 8'h00;
      cmd_valid_q <= 1'b0;
      pulse_q     <= '0;
      oe_q        <= 1'b0;
      out_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_sh_q     <= rx_sh_d;
      tx_sh_q     <= tx_sh_d;
      cmd_byte_q  <= cmd_byte_d;
      cmd_valid_q <= cmd_valid_d;
      pulse_q     <= pulse_d;
      oe_q        <= oe_d;
      out_q       <= out_d;
    end
  end

`ifdef U62_TIMEOUT_EN
  always_ff @(posedge PI_CLK or negedge RESET_n) begin
    if (!RESET_n) to_q <= '0;
    else          to_q <= to_d;
  end
`endif

  // ---------------------------------------------------------------- outputs
  assign sdata_out          = out_q;
  assign sdata_oe           = oe_q;
  assign cmd_if.cmd_byte    = cmd_byte_q;
  assign cmd_if.cmd_valid   = cmd_valid_q;
  assign cmd_if.cmd_play    = pulse_q[P_PLAY];
  assign cmd_if.cmd_stop    = pulse_q[P_STOP];
  assign cmd_if.cmd_rewind  = pulse_q[P_REW];
  assign cmd_if.cmd_ff      = pulse_q[P_FF];
  assign cmd_if.cmd_idle    = pulse_q[P_IDLE];
  assign cmd_if.cmd_unknown = pulse_q[P_UNK];
  assign cmd_if.busy        = (state_q != RX_IDLE);

endmodule

// File: tb/tb_u62_serial_link.sv
// Directed bench for u62_serial_link: U62 bus model plus command/reply scoreboard.
module tb_u62_serial_link;
  localparam int H = 100;  // SCK half period in PI_CLK cycles

  logic PI_CLK = 1'b0;
  logic RESET_n = 1'b0;
  logic sck_in = 1'b1;
  logic u62_oe = 1'b0;
  logic u62_drv = 1'b1;
  logic sdata_out, sdata_oe;
  logic sdata_in;

  int checks = 0;
  int failures = 0;

  logic [7:0] cq[$];
  logic [7:0] rq[$];
  logic       prev_valid = 1'b0;

  u62_serial_link_if bus();

  // Shared SDATA line with a pull-up: U62 drives during the command phase.
  assign sdata_in = u62_oe ? u62_drv : (sdata_oe ? sdata_out : 1'b1);

  u62_serial_link #(.TIMEOUT_CYCLES(1000)) dut (
    .PI_CLK   (PI_CLK),
    .RESET_n  (RESET_n),
    .sck_in   (sck_in),
    .sdata_in (sdata_in),
    .sdata_out(sdata_out),
    .sdata_oe (sdata_oe),
    .cmd_if   (bus.master)
  );

  always #1 PI_CLK = ~PI_CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] exp_pulses(input logic [7:0] c);
    case (c)
      8'h80:   return 6'b000001;
      8'h60:   return 6'b000010;
      8'h20:   return 6'b000100;
      8'h40:   return 6'b001000;
      8'h08:   return 6'b010000;
      default: return 6'b100000;
    endcase
  endfunction

  wire [5:0] pulses = {bus.cmd_unknown, bus.cmd_idle, bus.cmd_ff,
                       bus.cmd_rewind, bus.cmd_stop, bus.cmd_play};

  always @(negedge PI_CLK) begin
    logic [7:0] e;
    if (bus.cmd_valid) begin
      chk("cmd_pending", cq.size() != 0, 1);
      e = (cq.size() != 0) ? cq.pop_front() : 8'hxx;
      chk("cmd_byte", bus.cmd_byte, e);
      chk("cmd_pulses", pulses, exp_pulses(e));
      chk("valid_width", prev_valid, 0);
    end else if (|pulses) begin
      chk("stray_pulse", pulses, 0);
    end
    prev_valid = bus.cmd_valid;
  end

  task automatic send_cmd(input logic [7:0] c, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      sck_in = 1'b0;
      u62_oe = 1'b1;
      u62_drv = c[i];
      repeat (H) @(negedge PI_CLK);
      chk("no_contention", sdata_oe, 0);
      sck_in = 1'b1;
      repeat (H) @(negedge PI_CLK);
    end
    u62_oe = 1'b0;
  endtask

  task automatic reply(input int n, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < n; i++) begin
      sck_in = 1'b0;
      repeat (H) @(negedge PI_CLK);
      if (i == 0) chk("oe_after_fall", sdata_oe, 1);
      rx = {rx[6:0], sdata_in};
      sck_in = 1'b1;
      if (i == 0) bus.status_in = ~bus.status_in;  // must not disturb reply
      repeat (H) @(negedge PI_CLK);
    end
  endtask

  task automatic xfer(input logic [7:0] c, input logic [7:0] st);
    logic [7:0] rx;
    bus.status_in = st;
    cq.push_back(c);
    rq.push_back(st);
    send_cmd(c, 8);
    reply(8, rx);
    chk("reply_byte", rx, rq.pop_front());
    chk("oe_released", sdata_oe, 0);
    chk("out_released", sdata_out, 0);
    chk("busy_done", bus.busy, 0);
  endtask

  task automatic do_reset();
    @(negedge PI_CLK);
    RESET_n = 1'b0;
    #0.5;
    chk("rst_oe_async", sdata_oe, 0);
    chk("rst_busy", bus.busy, 0);
    sck_in = 1'b1;
    u62_oe = 1'b0;
    repeat (3) @(negedge PI_CLK);
    RESET_n = 1'b1;
    repeat (5) @(negedge PI_CLK);
  endtask

  initial begin
    logic [7:0] rx;
    bus.status_in = 8'h00;
    repeat (5) @(negedge PI_CLK);
    chk("reset_oe", sdata_oe, 0);
    chk("reset_out", sdata_out, 0);
    chk("reset_cmd_byte", bus.cmd_byte, 8'h00);
    chk("reset_busy", bus.busy, 0);
    chk("reset_valid", bus.cmd_valid, 0);
    RESET_n = 1'b1;
    repeat (5) @(negedge PI_CLK);

    xfer(8'h80, 8'h3C);   // play
    xfer(8'h00, 8'h0F);   // junk -> unknown
    xfer(8'h40, 8'hA5);   // ff, reply A5
    xfer(8'h20, 8'h81);   // rewind

    // reset after four command bits: no pulse may follow
    bus.status_in = 8'h99;
    send_cmd(8'h60, 4);
    chk("partial_busy", bus.busy, 1);
    do_reset();

    // reset during the reply: command pulse already issued
    bus.status_in = 8'hC3;
    cq.push_back(8'h08);
    send_cmd(8'h08, 8);
    reply(3, rx);
    chk("mid_reply_oe", sdata_oe, 1);
    chk("mid_reply_bits", rx, 8'h06);  // C3 = 1100_0011, first three bits 110
    do_reset();

    xfer(8'h60, 8'h5A);   // stop after recovery

    // stall after three bits
    bus.status_in = 8'h11;
    send_cmd(8'h55, 3);
`ifdef U62_TIMEOUT_EN
    begin
      int w;
      w = 0;
      while (bus.busy && w < 1200) begin
        @(negedge PI_CLK);
        w++;
      end
      chk("timeout_idle", bus.busy, 0);
      chk("timeout_oe", sdata_oe, 0);
      chk("timeout_in_time", w < 1000, 1);
    end
`else
    repeat (1200) @(negedge PI_CLK);
    chk("stall_busy", bus.busy, 1);
    do_reset();
`endif
    xfer(8'h08, 8'hE7);   // idle

    // back-to-back with no idle gap
    xfer(8'hFF, 8'h01);
    xfer(8'h80, 8'h80);

    repeat (10) @(negedge PI_CLK);
    chk("all_cmds_seen", cq.size(), 0);
    chk("all_replies_seen", rq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/u62_serial_link.md
Name: u62_serial_link

Overview:
- Byte-serial transceiver for the front-panel link to U62 (SCK/SDATA pins).
- Runs in the PI_CLK domain. U62 supplies the asynchronous SCK, which is synchronised and edge-detected inside the block.
- Each transaction is an 8-bit command from U62 followed by an 8-bit status reply to U62.
- Decodes commands into single-cycle pulses for the top-level transport control, and drives the SDATA tristate controls.

Parameters:
- SYNC_STAGES, 2, synchroniser depth for SCK and SDATA input (minimum 2).
- TIMEOUT_CYCLES, 200000, PI_CLK cycles without an SCK edge before a partial transaction is abandoned (1 ms at 200 MHz).
- TIMEOUT_W, 18, width of the timeout counter.

Ports:
- PI_CLK  in  1  system clock, 200 MHz.
- RESET_n  in  1  asynchronous active-low reset.
- sck_in  in  1  raw SCK pin from U62 (asynchronous).
- sdata_in  in  1  raw SDATA pin, read side.
- sdata_out  out  1  SDATA drive value; top level drives SDATA = sdata_oe ? sdata_out : 1'bz.
- sdata_oe  out  1  SDATA output enable.
- status_in  in  8  front-panel status byte to return; sampled at command completion.
- cmd_byte  out  8  last complete command byte.
- cmd_valid  out  1  one-cycle pulse when cmd_byte updates.
- cmd_play, cmd_stop, cmd_rewind, cmd_ff, cmd_idle  out  1 each  one-cycle decode pulses, coincident with cmd_valid.
- cmd_unknown  out  1  one-cycle pulse: valid byte matches no known code.
- busy  out  1  high whenever the state is not RX_IDLE.

Behaviour:
- Reset values: sdata_out=0, sdata_oe=0, cmd_byte=8'h00, all pulses=0, busy=0, state=RX_IDLE.
- Synchronised SCK and SDATA flops reset to 1 (idle-high line).
- Edge detect: sck_s is the synchronised SCK; sck_d is sck_s delayed by one cycle. rise = sck_s & ~sck_d; fall = ~sck_s & sck_d. A pin edge is seen SYNC_STAGES+1 cycles after it occurs.
- Bit order is MSB first in both directions.
- RX_IDLE:
  - On rise: shift in SDATA_s and set bit count to 1.
  - Go to RX_CMD.
- RX_CMD:
  - Each rise shifts SDATA_s into the shift register.
  - On the rise that completes the 8th bit, in the next cycle:
    - cmd_byte is loaded.
    - cmd_valid and the decode pulse are asserted for exactly one cycle.
    - status_in is captured into the tx shift register.
  - Then go to TX_WAIT.
- Decode table:
  - 8'b10000000 = play
  - 8'b01100000 = stop
  - 8'b00100000 = rewind
  - 8'b01000000 = ff
  - 8'b00001000 = idle
  - Any other value raises cmd_unknown.
  - Exactly one of the six pulses fires per cmd_valid.
- TX_WAIT:
  - On the first fall: sdata_oe=1, sdata_out=tx[7].
  - Go to TX_DATA with bit count 0.
- TX_DATA:
  - Each rise increments the bit count (U62 samples on rise).
  - Each fall, except the first, shifts tx left and drives the new tx[7].
  - On the rise completing the 8th bit: sdata_oe=0 on the next cycle, sdata_out=0, state goes to RX_IDLE.
- If rise and fall are flagged in the same cycle (impossible after synchronisation), rise takes priority.
- status_in changes after capture do not affect the reply in progress.
- Reset asserted mid-transaction: everything returns immediately to reset values and sdata_oe drops asynchronously. A partial command produces no pulse.
- No handshake with the consumer: pulses are fire-and-forget, and the consumer must accept one per cycle.

Optional Feature:
- Macro U62_TIMEOUT_EN.
- Defined:
  - A counter clears on every SCK edge and on return to RX_IDLE, and increments in any other state.
  - At TIMEOUT_CYCLES-1 it forces RX_IDLE and sdata_oe=0, discards the partial byte, and suppresses pulses.
  - The counter saturates and never wraps.
- Undefined: no counter. A stalled transaction holds its state until the next SCK edges or reset.

Test Plan:
- Reset with sck_in=1, then clock in 8'b10000000 MSB first (1 µs SCK period) -> cmd_byte=8'h80; cmd_valid and cmd_play high for exactly one cycle; all other pulses 0.
- Command 8'h01000000-style junk 8'h00 -> cmd_unknown pulse, no decode pulse; then 8'b01000000 -> cmd_ff pulse.
- status_in=8'hA5 at command end, changed to 8'h00 during the reply -> U62 samples 1,0,1,0,0,1,0,1 on SCK rises; sdata_oe asserted from the first fall, deasserted after the 8th rise; busy then 0.
- Assert RESET_n low after 4 command bits and during the reply -> no pulses, sdata_oe=0 immediately; the next full 8'b01100000 transaction yields cmd_stop.
- U62_TIMEOUT_EN defined, TIMEOUT_CYCLES=1000: stop SCK after 3 bits -> RX_IDLE with busy=0 within 1000 cycles; a fresh 8'b00001000 gives cmd_idle. With the macro undefined, busy stays 1.
- Back-to-back transactions with no gap -> two cmd_valid pulses with correct bytes; no SDATA contention, with sdata_oe low at the first command rise.
